// File: rtl/dmem_fill_pkg.sv
// Shared sizing constants and state encoding for the data-cache line-fill unit.
package dmem_fill_pkg;

   localparam int DMEM_LINE       = 256;
   localparam int DMEM_BLK_LEN    = 59;
   localparam int DMEM_BUS_BEAT_W = 64;

   typedef enum logic [1:0] {
      DMEM_FILL_S_IDLE = 2'd0,
      DMEM_FILL_S_REQ  = 2'd1,
      DMEM_FILL_S_DATA = 2'd2,
      DMEM_FILL_S_DONE = 2'd3
   } fill_state_t;

endpackage

// File: rtl/dmem_line_buf.sv
// Beat counter and line assembly buffer; beats land in incrementing slots.
module dmem_line_buf
   import dmem_fill_pkg::*;
#(
   parameter int LINE_W = DMEM_LINE,
   parameter int BEAT_W = DMEM_BUS_BEAT_W,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wr,
   input  logic [BEAT_W-1:0] data,
   output logic [CNT_W-1:0]  count,
   output logic              last,
   output logic [LINE_W-1:0] line
);

   localparam int BEATS = LINE_W / BEAT_W;

   assign last = (count == CNT_W'(BEATS - 1));

   // The line is never cleared by clr, so the last full line stays visible until a new beat lands.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         line  <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (wr) begin
         line[count*BEAT_W +: BEAT_W] <= data;
         count                        <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/dmem_fill.sv
// Line-fill unit: one burst read per cache line request, with snoop forwarding
// and refetch when a snoop hits the line being fetched.
module dmem_fill
   import dmem_fill_pkg::*;
#(
   parameter int LINE_W = DMEM_LINE,
   parameter int BLK_W  = DMEM_BLK_LEN,
   parameter int BEAT_W = DMEM_BUS_BEAT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BLK_W-1:0]  b_addr_d,
   input  logic              b_rd_d,
   output logic [LINE_W-1:0] b_rdata_d,
   output logic              b_dv_d,
   output logic [BLK_W-1:0]  b_inv_addr_d,
   output logic              inv,
   output logic [63:0]       m_addr,
   output logic              m_req,
   input  logic              m_ack,
   input  logic              m_rvalid,
   input  logic [BEAT_W-1:0] m_rdata,
   input  logic              m_rlast,
   input  logic              s_inv,
   input  logic [BLK_W-1:0]  s_inv_addr,
   output logic              err
);

   localparam int BEATS = LINE_W / BEAT_W;
   localparam int OFF   = $clog2(LINE_W / 8);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   fill_state_t      state;
   logic [BLK_W-1:0] blk;
   logic             stale;
   logic             snoop_hit;
   logic             buf_clr;
   logic             buf_wr;
   logic [CNT_W-1:0] count;
   logic             last;

   assign m_addr    = 64'({blk, {OFF{1'b0}}});
   assign snoop_hit = s_inv && (s_inv_addr == blk) &&
                      (state == DMEM_FILL_S_REQ || state == DMEM_FILL_S_DATA);
   assign buf_clr   = (state == DMEM_FILL_S_REQ) && m_ack;
   assign buf_wr    = (state == DMEM_FILL_S_DATA) && m_rvalid;

   dmem_line_buf #(
      .LINE_W (LINE_W),
      .BEAT_W (BEAT_W),
      .CNT_W  (CNT_W)
   ) u_line_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (buf_clr),
      .wr    (buf_wr),
      .data  (m_rdata),
      .count (count),
      .last  (last),
      .line  (b_rdata_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= DMEM_FILL_S_IDLE;
         blk          <= '0;
         stale        <= 1'b0;
         err          <= 1'b0;
         m_req        <= 1'b0;
         b_dv_d       <= 1'b0;
         inv          <= 1'b0;
         b_inv_addr_d <= '0;
      end else begin
         inv          <= s_inv;
         b_inv_addr_d <= s_inv_addr;
         b_dv_d       <= 1'b0;
         if (snoop_hit)
            stale <= 1'b1;
         case (state)
            DMEM_FILL_S_IDLE: begin
               if (m_rvalid)
                  err <= 1'b1;
               if (b_rd_d) begin
                  blk   <= b_addr_d;
                  m_req <= 1'b1;
                  state <= DMEM_FILL_S_REQ;
               end
            end
            DMEM_FILL_S_REQ: begin
               if (m_ack) begin
                  m_req <= 1'b0;
                  state <= DMEM_FILL_S_DATA;
               end
            end
            DMEM_FILL_S_DATA: begin
               if (m_rvalid) begin
                  // The counter, not m_rlast, ends the burst; a misplaced rlast is only flagged.
                  if (m_rlast != (count == CNT_W'(BEATS - 1)))
                     err <= 1'b1;
                  if (last) begin
                     if (stale || snoop_hit) begin
                        stale <= 1'b0;
                        m_req <= 1'b1;
                        state <= DMEM_FILL_S_REQ;
                     end else begin
                        b_dv_d <= 1'b1;
                        state  <= DMEM_FILL_S_DONE;
                     end
                  end
               end
            end
            DMEM_FILL_S_DONE: begin
               state <= DMEM_FILL_S_IDLE;
            end
            default: state <= DMEM_FILL_S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_fill.sv
// Self-checking bench for dmem_fill: directed scenarios plus randomized back-to-back fills.
module tb_dmem_fill;

   localparam int LINE_W = 256;
   localparam int BLK_W  = 59;
   localparam int BEAT_W = 64;
   localparam int BEATS  = LINE_W / BEAT_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [BLK_W-1:0]  b_addr_d = '0;
   logic              b_rd_d = 1'b0;
   logic [LINE_W-1:0] b_rdata_d;
   logic              b_dv_d;
   logic [BLK_W-1:0]  b_inv_addr_d;
   logic              inv;
   logic [63:0]       m_addr;
   logic              m_req;
   logic              m_ack = 1'b0;
   logic              m_rvalid = 1'b0;
   logic [BEAT_W-1:0] m_rdata = '0;
   logic              m_rlast = 1'b0;
   logic              s_inv = 1'b0;
   logic [BLK_W-1:0]  s_inv_addr = '0;
   logic              err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int t0 = 0;
   logic             inv_cap;
   logic [BLK_W-1:0] inv_addr_cap;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_fill dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .b_addr_d     (b_addr_d),
      .b_rd_d       (b_rd_d),
      .b_rdata_d    (b_rdata_d),
      .b_dv_d       (b_dv_d),
      .b_inv_addr_d (b_inv_addr_d),
      .inv          (inv),
      .m_addr       (m_addr),
      .m_req        (m_req),
      .m_ack        (m_ack),
      .m_rvalid     (m_rvalid),
      .m_rdata      (m_rdata),
      .m_rlast      (m_rlast),
      .s_inv        (s_inv),
      .s_inv_addr   (s_inv_addr),
      .err          (err)
   );

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [BLK_W-1:0] rand_blk();
      return BLK_W'({$urandom, $urandom});
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   // Acts as the system-bus slave for one burst; optional snoop on beat snp_beat.
   task automatic bus_burst(input logic [LINE_W-1:0] data, input int ack_dly, input int gap,
                            input int snp_beat, input logic [BLK_W-1:0] snp_addr,
                            input int rlast_beat, output int req_hi);
      int w;
      w = 0;
      req_hi = 0;
      while (!m_req && w < 20) begin
         step();
         w++;
      end
      checks++;
      if (m_req !== 1'b1) begin
         errors++;
         $display("FAIL bus_req_wait: m_req=%0b after %0d cycles, required 1", m_req, w);
         return;
      end
      for (int d = 0; d <= ack_dly; d++) begin
         if (m_req) req_hi++;
         m_ack = (d == ack_dly);
         step();
      end
      m_ack = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
         if (k == 2)
            for (int g = 0; g < gap; g++) begin
               if (m_req) req_hi++;
               step();
            end
         if (m_req) req_hi++;
         m_rvalid   = 1'b1;
         m_rdata    = data[k*BEAT_W +: BEAT_W];
         m_rlast    = (k == rlast_beat);
         s_inv      = (k == snp_beat);
         s_inv_addr = snp_addr;
         step();
         m_rvalid = 1'b0;
         m_rlast  = 1'b0;
         s_inv    = 1'b0;
         if (k == snp_beat) begin
            inv_cap      = inv;
            inv_addr_cap = b_inv_addr_d;
         end
      end
   endtask

   task automatic start_req(input logic [BLK_W-1:0] a);
      b_addr_d = a;
      b_rd_d   = 1'b1;
      t0       = cyc;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if ({m_req, b_dv_d, inv, err} !== 4'b0) begin
         errors++;
         $display("FAIL reset_ctrl: {m_req,dv,inv,err}=%b, required 0000", {m_req, b_dv_d, inv, err});
      end
      checks++;
      if (b_rdata_d !== '0) begin
         errors++;
         $display("FAIL reset_line: b_rdata_d=%h, required 0", b_rdata_d);
      end
      checks++;
      if (m_addr !== 64'h0 || b_inv_addr_d !== '0) begin
         errors++;
         $display("FAIL reset_addr: m_addr=%h inv_addr=%h, required 0", m_addr, b_inv_addr_d);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_fill();
      logic [LINE_W-1:0] line;
      int rh;
      line = {64'h44, 64'h33, 64'h22, 64'h11};
      start_req(59'h10);
      checks++;
      if (m_req !== 1'b1 || m_addr !== 64'h200) begin
         errors++;
         $display("FAIL single_req: m_req=%0b m_addr=%h, required 1 / 200", m_req, m_addr);
      end
      bus_burst(line, 0, 0, -1, '0, BEATS - 1, rh);
      checks++;
      if (b_dv_d !== 1'b1 || cyc - t0 !== 6) begin
         errors++;
         $display("FAIL single_dv: dv=%0b at cycle %0d, required 1 at 6", b_dv_d, cyc - t0);
      end
      checks++;
      if (b_rdata_d !== line || err !== 1'b0) begin
         errors++;
         $display("FAIL single_data: line=%h err=%0b, required %h err=0", b_rdata_d, err, line);
      end
      b_rd_d = 1'b0;
      step();
      checks++;
      if (b_dv_d !== 1'b0) begin
         errors++;
         $display("FAIL single_pulse: dv=%0b one cycle later, required 0", b_dv_d);
      end
   endtask

   task automatic test_wait_states();
      logic [LINE_W-1:0] line;
      int rh;
      line = rand_line();
      start_req(rand_blk());
      bus_burst(line, 3, 1, -1, '0, BEATS - 1, rh);
      checks++;
      if (b_dv_d !== 1'b1 || cyc - t0 !== 10) begin
         errors++;
         $display("FAIL wait_dv: dv=%0b at cycle %0d, required 1 at 10", b_dv_d, cyc - t0);
      end
      checks++;
      if (b_rdata_d !== line) begin
         errors++;
         $display("FAIL wait_data: line=%h, required %h", b_rdata_d, line);
      end
      checks++;
      if (rh !== 4) begin
         errors++;
         $display("FAIL wait_req_len: m_req high %0d cycles, required 4", rh);
      end
      b_rd_d = 1'b0;
      step();
   endtask

   task automatic test_snoop_hit();
      int beats_at[2];
      logic [LINE_W-1:0] l1, l2;
      int rh;
      beats_at[0] = 1;
      beats_at[1] = BEATS - 1;
      for (int i = 0; i < 2; i++) begin
         l1 = rand_line();
         l2 = rand_line();
         start_req(59'h10);
         bus_burst(l1, 0, 0, beats_at[i], 59'h10, BEATS - 1, rh);
         checks++;
         if (inv_cap !== 1'b1 || inv_addr_cap !== 59'h10) begin
            errors++;
            $display("FAIL hit_fwd: inv=%0b addr=%h, required 1 / 10", inv_cap, inv_addr_cap);
         end
         checks++;
         if (m_req !== 1'b1 || b_dv_d !== 1'b0) begin
            errors++;
            $display("FAIL hit_refetch: m_req=%0b dv=%0b after burst, required 1 / 0", m_req, b_dv_d);
         end
         bus_burst(l2, 0, 0, -1, '0, BEATS - 1, rh);
         checks++;
         if (b_dv_d !== 1'b1 || cyc - t0 !== 11 || b_rdata_d !== l2) begin
            errors++;
            $display("FAIL hit_deliver: dv=%0b cycle=%0d line=%h, required 1 / 11 / %h",
                     b_dv_d, cyc - t0, b_rdata_d, l2);
         end
         b_rd_d = 1'b0;
         step();
      end
   endtask

   task automatic test_snoop_miss();
      logic [LINE_W-1:0] l1;
      int rh;
      l1 = rand_line();
      start_req(59'h10);
      bus_burst(l1, 0, 0, 1, 59'h11, BEATS - 1, rh);
      checks++;
      if (inv_cap !== 1'b1 || inv_addr_cap !== 59'h11) begin
         errors++;
         $display("FAIL miss_fwd: inv=%0b addr=%h, required 1 / 11", inv_cap, inv_addr_cap);
      end
      checks++;
      if (b_dv_d !== 1'b1 || cyc - t0 !== 6 || b_rdata_d !== l1) begin
         errors++;
         $display("FAIL miss_deliver: dv=%0b cycle=%0d line=%h, required 1 / 6 / %h",
                  b_dv_d, cyc - t0, b_rdata_d, l1);
      end
      b_rd_d = 1'b0;
      step();
   endtask

   task automatic test_snoop_done();
      logic [LINE_W-1:0] l1;
      logic [BLK_W-1:0] a;
      int rh;
      l1 = rand_line();
      a  = rand_blk();
      start_req(a);
      bus_burst(l1, 0, 0, -1, '0, BEATS - 1, rh);
      s_inv      = 1'b1;
      s_inv_addr = a;
      b_rd_d     = 1'b0;
      checks++;
      if (b_dv_d !== 1'b1 || b_rdata_d !== l1) begin
         errors++;
         $display("FAIL done_deliver: dv=%0b line=%h, required 1 / %h", b_dv_d, b_rdata_d, l1);
      end
      step();
      s_inv = 1'b0;
      checks++;
      if (inv !== 1'b1 || b_inv_addr_d !== a || m_req !== 1'b0 || b_dv_d !== 1'b0) begin
         errors++;
         $display("FAIL done_snoop: inv=%0b addr=%h m_req=%0b dv=%0b, required 1 / %h / 0 / 0",
                  inv, b_inv_addr_d, m_req, b_dv_d, a);
      end
   endtask

   task automatic test_back_to_back_snoops();
      logic [BLK_W-1:0] a;
      for (int i = 0; i < 6; i++) begin
         a          = rand_blk();
         s_inv      = 1'b1;
         s_inv_addr = a;
         step();
         checks++;
         if (inv !== 1'b1 || b_inv_addr_d !== a) begin
            errors++;
            $display("FAIL snoop_stream[%0d]: inv=%0b addr=%h, required 1 / %h", i, inv, b_inv_addr_d, a);
         end
      end
      s_inv = 1'b0;
      step();
      checks++;
      if (inv !== 1'b0) begin
         errors++;
         $display("FAIL snoop_stream_end: inv=%0b, required 0", inv);
      end
   endtask

   task automatic test_errors();
      logic [LINE_W-1:0] l1;
      int rh;
      l1 = rand_line();
      start_req(rand_blk());
      bus_burst(l1, 0, 0, -1, '0, 2, rh);
      checks++;
      if (err !== 1'b1 || b_dv_d !== 1'b1 || cyc - t0 !== 6 || b_rdata_d !== l1) begin
         errors++;
         $display("FAIL err_early_rlast: err=%0b dv=%0b cycle=%0d, required 1 / 1 / 6 with data", err, b_dv_d, cyc - t0);
      end
      b_rd_d = 1'b0;
      rst_n  = 1'b0;
      step();
      rst_n    = 1'b1;
      m_rvalid = 1'b1;
      step();
      m_rvalid = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_stray_beat: err=%0b, required 1", err);
      end
      step();
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: err=%0b, required 1", err);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      start_req(rand_blk());
      bus_burst(l1, 0, 0, -1, '0, 99, rh);
      checks++;
      if (err !== 1'b1 || b_dv_d !== 1'b1) begin
         errors++;
         $display("FAIL err_missing_rlast: err=%0b dv=%0b, required 1 / 1", err, b_dv_d);
      end
      b_rd_d = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_burst();
      logic [LINE_W-1:0] l1;
      int rh;
      start_req(rand_blk());
      m_ack = 1'b1;
      step();
      m_ack = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_rvalid = 1'b1;
         m_rdata  = {$urandom, $urandom} | 64'h1;
         step();
      end
      m_rvalid = 1'b0;
      rst_n    = 1'b0;
      step();
      checks++;
      if (m_req !== 1'b0 || b_dv_d !== 1'b0 || b_rdata_d !== '0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: m_req=%0b dv=%0b line=%h err=%0b, required 0 / 0 / 0 / 0",
                  m_req, b_dv_d, b_rdata_d, err);
      end
      rst_n = 1'b1;
      l1    = rand_line();
      start_req(rand_blk());
      bus_burst(l1, 0, 0, -1, '0, BEATS - 1, rh);
      checks++;
      if (b_dv_d !== 1'b1 || cyc - t0 !== 6 || b_rdata_d !== l1 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_refill: dv=%0b cycle=%0d err=%0b line=%h, required 1 / 6 / 0 / %h",
                  b_dv_d, cyc - t0, err, b_rdata_d, l1);
      end
      b_rd_d = 1'b0;
      step();
   endtask

   // Back-to-back random fills; model: a matching snoop during a burst costs one extra burst,
   // each burst takes 1 request cycle + ack wait + gaps + BEATS beats, plus the sample cycle.
   task automatic test_random();
      logic [LINE_W-1:0] l1, l2, exp_line;
      logic [BLK_W-1:0] a, sa;
      int kind, sb, ack1, gap1, ack2, gap2, exp_lat, rh;
      for (int it = 0; it < 25; it++) begin
         a    = rand_blk();
         l1   = rand_line();
         l2   = rand_line();
         kind = $urandom_range(0, 2);
         sb   = $urandom_range(0, BEATS - 1);
         ack1 = $urandom_range(0, 3);
         gap1 = $urandom_range(0, 2);
         ack2 = $urandom_range(0, 3);
         gap2 = $urandom_range(0, 2);
         sa   = (kind == 1) ? a : (a ^ (BLK_W'(1) << $urandom_range(0, BLK_W - 1)));
         exp_lat  = 1 + (1 + ack1 + gap1 + BEATS) + ((kind == 1) ? (1 + ack2 + gap2 + BEATS) : 0);
         exp_line = (kind == 1) ? l2 : l1;
         start_req(a);
         bus_burst(l1, ack1, gap1, (kind == 0) ? -1 : sb, sa, BEATS - 1, rh);
         if (kind == 1) bus_burst(l2, ack2, gap2, -1, '0, BEATS - 1, rh);
         if (kind != 0) begin
            checks++;
            if (inv_cap !== 1'b1 || inv_addr_cap !== sa) begin
               errors++;
               $display("FAIL rand_fwd[%0d]: inv=%0b addr=%h, required 1 / %h", it, inv_cap, inv_addr_cap, sa);
            end
         end
         checks++;
         if (b_dv_d !== 1'b1 || cyc - t0 !== exp_lat || b_rdata_d !== exp_line || err !== 1'b0) begin
            errors++;
            $display("FAIL rand_fill[%0d]: dv=%0b cycle=%0d err=%0b line=%h, required 1 / %0d / 0 / %h",
                     it, b_dv_d, cyc - t0, err, b_rdata_d, exp_lat, exp_line);
         end
         step();
      end
      b_rd_d = 1'b0;
      step();
   endtask

   initial begin
      step();
      test_reset();
      test_single_fill();
      test_wait_states();
      test_snoop_hit();
      test_snoop_miss();
      test_snoop_done();
      test_back_to_back_snoops();
      test_errors();
      test_reset_mid_burst();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
